// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that shares one SPI byte engine between NUM_REQ clients,
// framing each client's multi-byte burst under a single chip-select assertion.
module spi_txn_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   req_len,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     byte_ack,
    output logic [7:0]             rx_data,
    output logic                   txn_done,
    output logic                   txn_err,
    output logic                   cs,
    output logic                   eng_start,
    output logic [7:0]             eng_data,
    input  logic                   eng_done,
    input  logic [7:0]             eng_rx
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [PW:0] NR = (PW + 1)'(NUM_REQ);

    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, GAP} state_t;

    state_t             state, state_d;
    logic [PW-1:0]      ptr, ptr_d;
    logic [2:0]         bcnt, bcnt_d;
    logic [TW-1:0]      tcnt, tcnt_d;
    logic [GW-1:0]      gcnt, gcnt_d;
    logic [NUM_REQ-1:0] gnt_d, ack_d;
    logic [7:0]         rx_d;
    logic               cs_d, done_d, err_d;

    logic [PW-1:0]      winner;
    logic               found;
    logic [PW:0]        cand;
    logic [2:0]         len_sel;

    // Search upward from ptr+1 with wrap; the first hit wins.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (PW + 1)'(k);
            if (cand >= NR) cand = cand - NR;
            if (!found && req[cand[PW-1:0]]) begin
                found  = 1'b1;
                winner = cand[PW-1:0];
            end
        end
    end

    assign len_sel = req_len[3*int'(winner) +: 3];

    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        bcnt_d    = bcnt;
        tcnt_d    = tcnt;
        gcnt_d    = gcnt;
        gnt_d     = gnt;
        ack_d     = '0;
        rx_d      = rx_data;
        cs_d      = cs;
        done_d    = 1'b0;
        err_d     = 1'b0;
        eng_start = 1'b0;
        eng_data  = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    ptr_d   = winner;
                    gnt_d   = NUM_REQ'(1) << winner;
                    bcnt_d  = (len_sel == 3'd0) ? 3'd1 : len_sel;
                    cs_d    = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = START;
            START: begin
                eng_start = 1'b1;
                eng_data  = req_data[8*int'(ptr) +: 8];
                tcnt_d    = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    rx_d   = eng_rx;
                    ack_d  = gnt;
                    bcnt_d = bcnt - 3'd1;
                    if (bcnt == 3'd1) begin
                        cs_d    = 1'b1;
                        done_d  = 1'b1;
                        gnt_d   = '0;
                        gcnt_d  = '0;
                        state_d = GAP;
                    end else begin
                        state_d = START;
                    end
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    // TIMEOUT full WAIT cycles have elapsed without a byte
                    cs_d    = 1'b1;
                    err_d   = 1'b1;
                    gnt_d   = '0;
                    gcnt_d  = '0;
                    state_d = GAP;
                end else if (tcnt != TW'(TIMEOUT)) begin
                    tcnt_d = tcnt + 1'b1;
                end
            end
            GAP: begin
                if (gcnt == GW'(GAP_CYCLES - 1)) state_d = IDLE;
                else                             gcnt_d  = gcnt + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= PW'(NUM_REQ - 1);
            bcnt     <= '0;
            tcnt     <= '0;
            gcnt     <= '0;
            gnt      <= '0;
            byte_ack <= '0;
            rx_data  <= '0;
            cs       <= 1'b1;
            txn_done <= 1'b0;
            txn_err  <= 1'b0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            bcnt     <= bcnt_d;
            tcnt     <= tcnt_d;
            gcnt     <= gcnt_d;
            gnt      <= gnt_d;
            byte_ack <= ack_d;
            rx_data  <= rx_d;
            cs       <= cs_d;
            txn_done <= done_d;
            txn_err  <= err_d;
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: transaction-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_spi_txn_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int GAP_CYCLES = 2;
    localparam int TIMEOUT    = 255;
    localparam int LAT        = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NUM_REQ-1:0]   req = '0;
    logic [3*NUM_REQ-1:0] req_len = '0;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   gnt, byte_ack;
    logic [7:0]           rx_data, eng_data;
    logic                 txn_done, txn_err, cs, eng_start;
    logic                 eng_done = 1'b0;
    logic [7:0]           eng_rx = 8'h00;

    int nerr = 0;
    int nchk = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    spi_txn_arbiter #(.NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len), .req_data(req_data),
        .gnt(gnt), .byte_ack(byte_ack), .rx_data(rx_data), .txn_done(txn_done),
        .txn_err(txn_err), .cs(cs), .eng_start(eng_start), .eng_data(eng_data),
        .eng_done(eng_done), .eng_rx(eng_rx)
    );

    // Requesters: each walks its own byte table, presenting the next byte as
    // soon as byte_ack is seen.
    logic [7:0] mem [NUM_REQ][8];
    logic [2:0] cnt [NUM_REQ] = '{default: 3'd0};

    always @(posedge clk)
        for (int i = 0; i < NUM_REQ; i++)
            if (byte_ack[i]) cnt[i] <= cnt[i] + 3'd1;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_data[8*i +: 8] = mem[i][cnt[i] + 3'(byte_ack[i])];
    end

    // Engine: echoes ~data LAT cycles after eng_start; can be muted or made to
    // emit a stray eng_done.
    int         cd = 0;
    logic [7:0] ed = 8'h00;
    bit         mute = 0;
    int         spur_req = 0, spur_ack = 0;

    always @(negedge clk) begin
        eng_done = 1'b0;
        if (reset) cd = 0;
        else begin
            if (cd == 1) begin eng_done = 1'b1; eng_rx = ~ed; end
            if (cd > 0) cd--;
            if (spur_req != spur_ack) begin eng_done = 1'b1; eng_rx = 8'h77; spur_ack = spur_req; end
            if (eng_start && !mute) begin cd = LAT; ed = eng_data; end
        end
    end

    // Reference model: walks each transaction as a timeline of edges.
    logic [NUM_REQ-1:0]   exp_gnt, exp_ack;
    logic [7:0]           exp_rx, exp_edata;
    logic                 exp_done, exp_err, exp_cs, exp_start;
    int                   mptr;
    logic [2:0]           mcnt [NUM_REQ];
    bit                   s_rst, s_done;
    logic [7:0]           s_rx;
    logic [NUM_REQ-1:0]   s_req;
    logic [3*NUM_REQ-1:0] s_len;

    task automatic tick();
        @(posedge clk);
        s_rst = reset; s_done = eng_done; s_rx = eng_rx; s_req = req; s_len = req_len;
        exp_ack = '0; exp_done = 0; exp_err = 0; exp_start = 0; exp_edata = '0;
        if (s_rst) begin
            exp_gnt = '0; exp_rx = '0; exp_cs = 1'b1; mptr = NUM_REQ - 1;
        end
    endtask

    task automatic model_txn();
        int w, len;
        bit got;
        do begin
            tick();
            if (s_rst) return;
        end while (s_req == '0);
        w = -1;
        for (int k = 1; k <= NUM_REQ; k++)
            if (w < 0 && s_req[(mptr + k) % NUM_REQ]) w = (mptr + k) % NUM_REQ;
        mptr = w;
        len = int'(s_len[3*w +: 3]);
        if (len == 0) len = 1;
        exp_gnt = NUM_REQ'(1) << w;
        exp_cs = 1'b0;
        tick(); if (s_rst) return;
        for (int b = 0; b < len; b++) begin
            exp_start = 1'b1;
            exp_edata = mem[w][mcnt[w]];
            tick(); if (s_rst) return;
            got = 0;
            for (int t = 0; t < TIMEOUT && !got; t++) begin
                tick(); if (s_rst) return;
                got = s_done;
            end
            if (!got) begin
                exp_cs = 1'b1; exp_err = 1'b1; exp_gnt = '0;
                break;
            end
            exp_ack = NUM_REQ'(1) << w;
            exp_rx  = s_rx;
            mcnt[w] = mcnt[w] + 3'd1;
            if (b == len - 1) begin
                exp_cs = 1'b1; exp_done = 1'b1; exp_gnt = '0;
            end
        end
        repeat (GAP_CYCLES) begin
            tick(); if (s_rst) return;
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) mcnt[i] = 3'd0;
        forever model_txn();
    end

    // Event log of DUT activity for the directed literal checks.
    int                 cyc = 0, last_st = 0, err_cyc = 0, run = 0;
    logic [7:0]         st_q[$], ack_q[$];
    logic [NUM_REQ-1:0] ackw_q[$];
    int                 gr_q[$], gap_q[$];
    logic [NUM_REQ-1:0] pgnt = '0;

    always @(negedge clk) begin
        cyc++;
        if (eng_start === 1'b1) begin st_q.push_back(eng_data); last_st = cyc; end
        if (byte_ack != '0) begin ack_q.push_back(rx_data); ackw_q.push_back(byte_ack); end
        if (gnt != '0 && pgnt == '0)
            for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) gr_q.push_back(i);
        pgnt = gnt;
        if (txn_err === 1'b1) err_cyc = cyc;
        if (cs === 1'b1) run++;
        else begin
            if (run > 0) gap_q.push_back(run);
            run = 0;
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic wait_ev(input int budget, input string n);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (txn_done || txn_err) ok = 1;
        end
        chk({n, "_end_seen"}, 32'(ok), 32'd1);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sb, ab, gb, pb, ok;
        int fo[5];
        logic [7:0] tx3[3], rx3[3], rx0;
        fo  = '{0, 1, 2, 3, 0};
        tx3 = '{8'hA5, 8'h3C, 8'hFF};
        rx3 = '{8'h5A, 8'hC3, 8'h00};
        for (int i = 0; i < NUM_REQ; i++)
            for (int j = 0; j < 8; j++) mem[i][j] = 8'((i << 4) + j + 1);
        mem[0][0] = 8'hA5; mem[0][1] = 8'h3C; mem[0][2] = 8'hFF;

        fork
            forever @(negedge clk) if (chk_en) begin
                chk("gnt", gnt, exp_gnt);
                chk("byte_ack", byte_ack, exp_ack);
                chk("rx_data", rx_data, exp_rx);
                chk("txn_done", txn_done, exp_done);
                chk("txn_err", txn_err, exp_err);
                chk("cs", cs, exp_cs);
                chk("eng_start", eng_start, exp_start);
                if (exp_start) chk("eng_data", eng_data, exp_edata);
            end
        join_none

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_en = 1;
        @(negedge clk);
        chk("rst_cs", cs, 1); chk("rst_gnt", gnt, 0);
        chk("rst_rx", rx_data, 0); chk("rst_eng_start", eng_start, 0);
        #1 reset = 1'b0;

        // Single 3-byte burst on requester 0
        sb = st_q.size(); ab = ack_q.size();
        req_len[0 +: 3] = 3'd3; req = 4'b0001;
        wait_ev(200, "single");
        req = '0;
        chk("single_done", txn_done, 1);
        chk("single_nstart", st_q.size() - sb, 3);
        chk("single_nack", ack_q.size() - ab, 3);
        if (st_q.size() >= sb + 3 && ack_q.size() >= ab + 3)
            for (int k = 0; k < 3; k++) begin
                chk("single_tx", st_q[sb+k], tx3[k]);
                chk("single_rx", ack_q[ab+k], rx3[k]);
                chk("single_ackw", ackw_q[ab+k], 4'b0001);
            end

        // Reset during the second byte of a 4-byte burst on requester 1
        repeat (6) @(negedge clk);
        req_len[3 +: 3] = 3'd4; req = 4'b0010;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (byte_ack[1]) ok = 1;
        end
        chk("rst_first_ack", ok, 1);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1; req = '0;
        @(negedge clk);
        chk("midrst_cs", cs, 1); chk("midrst_gnt", gnt, 0);
        chk("midrst_ack", byte_ack, 0); chk("midrst_done", txn_done, 0);
        chk("midrst_err", txn_err, 0); chk("midrst_start", eng_start, 0);
        #1 reset = 1'b0;

        // Fairness with all four requesting single bytes
        req_len = {4{3'd1}}; req = 4'b1111;
        gb = gr_q.size(); pb = gap_q.size();
        repeat (5) wait_ev(100, "fair");
        req = '0;
        chk("fair_ngrants", gr_q.size() - gb, 5);
        if (gr_q.size() >= gb + 5)
            for (int k = 0; k < 5; k++) chk("fair_order", gr_q[gb+k], fo[k]);
        chk("fair_ngaps", gap_q.size() - pb, 5);
        if (gap_q.size() >= pb + 5)
            for (int k = 1; k < 5; k++) chk("fair_cs_gap", gap_q[pb+k], GAP_CYCLES + 1);

        // len=0 on requester 2 moves exactly one byte
        repeat (4) @(negedge clk);
        #1 req_len[6 +: 3] = 3'd0; req = 4'b0100;
        sb = st_q.size(); ab = ack_q.size();
        wait_ev(100, "len0");
        req = '0;
        chk("len0_done", txn_done, 1);
        chk("len0_nstart", st_q.size() - sb, 1);
        chk("len0_nack", ack_q.size() - ab, 1);
        if (ackw_q.size() > 0) chk("len0_ackw", ackw_q[$], 4'b0100);

        // Timeout: engine silent
        repeat (4) @(negedge clk);
        #1 mute = 1; req_len[9 +: 3] = 3'd2; req = 4'b1000;
        ab = ack_q.size();
        wait_ev(400, "timeout");
        req = '0; mute = 0;
        chk("to_err", txn_err, 1);
        chk("to_latency", err_cyc - last_st, TIMEOUT + 1);
        chk("to_nack", ack_q.size() - ab, 0);
        chk("to_cs", cs, 1); chk("to_gnt", gnt, 0);

        // Next request is served normally
        req_len[0 +: 3] = 3'd1; req = 4'b0001;
        ab = ack_q.size();
        wait_ev(100, "after_to");
        req = '0;
        chk("after_to_done", txn_done, 1);
        chk("after_to_nack", ack_q.size() - ab, 1);

        // Stray eng_done in GAP, then in IDLE
        rx0 = rx_data;
        spur_req++;
        repeat (6) @(negedge clk);
        spur_req++;
        repeat (4) @(negedge clk);
        #1;
        chk("spur_rx", rx_data, rx0);
        chk("spur_nack", ack_q.size() - ab, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
